// File: rtl/font_glyph_pixel_reader_if.sv
// Request/response, cache-invalidate and flash read signals of the glyph pixel reader.
// master = requester and flash side (testbench/system), slave = the reader itself.
interface font_glyph_pixel_reader_if #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned WORD_W = 32
);
    localparam int unsigned IDX_W   = $clog2(WORD_W);
    localparam int unsigned WADDR_W = ADDR_W - IDX_W;

    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_bit_addr;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_pixel;
    logic               rsp_err;
    logic               cache_inval;
    logic               flash_req;
    logic [WADDR_W-1:0] flash_addr;
    logic               flash_rvalid;
    logic [WORD_W-1:0]  flash_rdata;

    modport master (
        output req_valid, req_bit_addr, rsp_ready, cache_inval, flash_rvalid, flash_rdata,
        input  req_ready, rsp_valid, rsp_pixel, rsp_err, flash_req, flash_addr
    );

    modport slave (
        input  req_valid, req_bit_addr, rsp_ready, cache_inval, flash_rvalid, flash_rdata,
        output req_ready, rsp_valid, rsp_pixel, rsp_err, flash_req, flash_addr
    );
endinterface

// File: rtl/font_glyph_pixel_reader.sv
// Fetches the flash word holding a glyph bit offset and returns that pixel (MSB-first within the word).
// Define WORD_CACHE_EN to add a one-word cache that serves runs of adjacent pixels without flash reads.
module font_glyph_pixel_reader #(
    parameter int unsigned ADDR_W         = 30,
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    font_glyph_pixel_reader_if.slave        bus
);
    localparam int unsigned IDX_W   = $clog2(WORD_W);
    localparam int unsigned WADDR_W = ADDR_W - IDX_W;
    localparam int unsigned TMO_W   = 16;
    localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(WORD_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_RESP} state_e;

    state_e             state_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic               rsp_pixel_q;
    logic               rsp_err_q;
    logic               flash_req_q;
    logic [WADDR_W-1:0] waddr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TMO_W-1:0]   tmo_cnt_q;

    logic               accept_c;
    logic               hit_c;
    logic               hit_pixel_c;
    logic [WADDR_W-1:0] req_waddr_c;
    logic [IDX_W-1:0]   req_idx_c;
    logic [IDX_W-1:0]   fetch_sel_c;

    assign req_waddr_c = bus.req_bit_addr[ADDR_W-1:IDX_W];
    assign req_idx_c   = bus.req_bit_addr[IDX_W-1:0];
    assign accept_c    = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;
    // Bit 0 of the offset is the word MSB.
    assign fetch_sel_c = MSB_IDX - idx_q;

`ifdef WORD_CACHE_EN
    logic               cache_vld_q;
    logic [WADDR_W-1:0] cache_waddr_q;
    logic [WORD_W-1:0]  cache_data_q;
    logic               inval_seen_q;
    logic [IDX_W-1:0]   hit_sel_c;

    assign hit_sel_c   = MSB_IDX - req_idx_c;
    assign hit_c       = cache_vld_q && (cache_waddr_q == req_waddr_c) && !bus.cache_inval;
    assign hit_pixel_c = cache_data_q[hit_sel_c];

    // A word whose fetch overlapped an invalidate is used once but never cached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_vld_q   <= 1'b0;
            cache_waddr_q <= '0;
            cache_data_q  <= '0;
            inval_seen_q  <= 1'b0;
        end else begin
            if (accept_c) begin
                inval_seen_q <= 1'b0;
            end else if ((state_q == ST_FETCH) && bus.cache_inval) begin
                inval_seen_q <= 1'b1;
            end
            if (bus.cache_inval) begin
                cache_vld_q <= 1'b0;
            end else if ((state_q == ST_FETCH) && bus.flash_rvalid && !inval_seen_q) begin
                cache_vld_q   <= 1'b1;
                cache_waddr_q <= waddr_q;
                cache_data_q  <= bus.flash_rdata;
            end
        end
    end
`else
    logic unused_cache_inval;

    assign unused_cache_inval = bus.cache_inval;
    assign hit_c              = 1'b0;
    assign hit_pixel_c        = 1'b0;
`endif

    // Request sequencer: one request in flight, response held until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_pixel_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            flash_req_q <= 1'b0;
            waddr_q     <= '0;
            idx_q       <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept_c) begin
                        req_ready_q <= 1'b0;
                        waddr_q     <= req_waddr_c;
                        idx_q       <= req_idx_c;
                        tmo_cnt_q   <= '0;
                        if (hit_c) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_pixel_q <= hit_pixel_c;
                            rsp_err_q   <= 1'b0;
                        end else begin
                            state_q     <= ST_FETCH;
                            flash_req_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    // Returned data beats a timeout landing on the same edge.
                    if (bus.flash_rvalid) begin
                        state_q     <= ST_RESP;
                        flash_req_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_pixel_q <= bus.flash_rdata[fetch_sel_c];
                        rsp_err_q   <= 1'b0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q     <= ST_RESP;
                        flash_req_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_pixel_q <= 1'b0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    flash_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_pixel  = rsp_pixel_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.flash_req  = flash_req_q;
    assign bus.flash_addr = waddr_q;

endmodule

// File: tb/tb_font_glyph_pixel_reader.sv
// Randomized scoreboard bench for font_glyph_pixel_reader: flash memory model, latency planner and pixel monitor.
// Expectations follow WORD_CACHE_EN the same way the design does.
module tb_font_glyph_pixel_reader;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned WORD_W = 32;
    localparam int          TMO    = 255;
`ifdef WORD_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    typedef struct {
        logic pixel;
        logic err;
        bit   hit;
        int   accept_cyc;
        int   fetch_snap;
    } exp_t;

    typedef struct {
        int          lat;   // FETCH cycle in which rvalid is driven; 0 = never
        logic [24:0] waddr;
        bit          abort;
    } plan_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    font_glyph_pixel_reader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    font_glyph_pixel_reader #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int issued = 0;
    int rsp_count = 0;
    int fetch_cycles = 0;
    int rvalid_cyc = 0;
    int late_req = 0;

    exp_t  sb[$];
    plan_t plan_q[$];
    logic [31:0] mem [int unsigned];
    bit          m_vld = 1'b0;
    logic [24:0] m_waddr = '0;

    function automatic logic [31:0] rd_word(input logic [24:0] w);
        if (mem.exists(32'(w))) return mem[32'(w)];
        return 32'(w) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic pixel_of(input logic [29:0] addr);
        logic [31:0] word;
        word = rd_word(addr[29:5]) >> (31 - int'(addr[4:0]));
        return word[0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Flash controller model: answers each fetch per the planned latency.
    initial begin : flash_model
        plan_t p;
        bit    active;
        int    cnt;
        int    late_done;
        active = 1'b0;
        cnt = 0;
        late_done = 0;
        p = '{lat: 1, waddr: '0, abort: 1'b0};
        bus.flash_rvalid = 1'b0;
        bus.flash_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.flash_rvalid = 1'b0;
            bus.flash_rdata  = $urandom;
            if (bus.flash_req === 1'b1) fetch_cycles++;
            if (active && bus.flash_req !== 1'b1) begin
                active = 1'b0;
                if (!p.abort) check("flash_req_cycles", 64'(cnt), 64'(p.lat == 0 ? TMO : p.lat));
            end
            if (bus.flash_req === 1'b1 && !active) begin
                if (plan_q.size() == 0) begin
                    fail_now("unexpected_fetch", "flash_req with no fetch expected");
                    p = '{lat: 1, waddr: bus.flash_addr, abort: 1'b0};
                end else begin
                    p = plan_q.pop_front();
                end
                check("flash_addr", 64'(bus.flash_addr), 64'(p.waddr));
                active = 1'b1;
                cnt = 0;
            end
            if (active) begin
                cnt++;
                if (p.lat != 0 && cnt == p.lat) begin
                    bus.flash_rvalid = 1'b1;
                    bus.flash_rdata  = rd_word(bus.flash_addr);
                    rvalid_cyc = cyc + 1;
                end
            end
            if (late_done != late_req) begin
                late_done = late_req;
                bus.flash_rvalid = 1'b1;
                bus.flash_rdata  = 32'hFFFF_FFFF;
            end
        end
    end

    // Response monitor: random backpressure, latency, stability and payload checks.
    initial begin : rsp_monitor
        exp_t e;
        bit   in_rsp;
        logic hold_pix;
        logic hold_err;
        in_rsp = 1'b0;
        hold_pix = 1'b0;
        hold_err = 1'b0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_ready = ($urandom_range(0, 99) < 65);
            if (reset) begin
                in_rsp = 1'b0;
                continue;
            end
            if (bus.rsp_valid === 1'b1) begin
                if (!in_rsp) begin
                    check("req_ready_low_in_rsp", 64'(bus.req_ready), 64'(0));
                    if (sb.size() == 0) begin
                        fail_now("unexpected_rsp", "rsp_valid with no request outstanding");
                    end else begin
                        e = sb[0];
                        if (e.hit) begin
                            check("hit_latency", 64'(cyc), 64'(e.accept_cyc));
                            check("hit_no_flash", 64'(fetch_cycles), 64'(e.fetch_snap));
                        end else if (e.err) begin
                            check("timeout_latency", 64'(cyc), 64'(e.accept_cyc + TMO));
                        end else begin
                            check("miss_latency", 64'(cyc), 64'(rvalid_cyc));
                        end
                    end
                end else begin
                    check("rsp_pixel_stable", 64'(bus.rsp_pixel), 64'(hold_pix));
                    check("rsp_err_stable", 64'(bus.rsp_err), 64'(hold_err));
                end
                hold_pix = bus.rsp_pixel;
                hold_err = bus.rsp_err;
                if (bus.rsp_ready) begin
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("rsp_pixel", 64'(bus.rsp_pixel), 64'(e.pixel));
                        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    end
                    rsp_count++;
                    in_rsp = 1'b0;
                end else begin
                    in_rsp = 1'b1;
                end
            end else if (in_rsp) begin
                fail_now("rsp_valid_dropped", "rsp_valid fell before handshake");
                in_rsp = 1'b0;
            end
        end
    end

    task automatic change_word(input logic [24:0] w, input logic [31:0] val);
        @(negedge clk);
        mem[32'(w)] = val;
        bus.cache_inval = 1'b1;
        m_vld = 1'b0;
        @(negedge clk);
        bus.cache_inval = 1'b0;
    endtask

    task automatic do_req(input logic [29:0] addr, input int lat, input bit inv_acc, input bit inv_mid);
        exp_t        e;
        logic [24:0] w;
        bit          hit;
        int          guard;
        w   = addr[29:5];
        hit = CACHE_EN && m_vld && (m_waddr == w) && !inv_acc;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_bit_addr = addr;
        bus.cache_inval  = inv_acc;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (bus.req_ready !== 1'b1) begin
            fail_now("req_accept", "req_ready never rose");
            bus.req_valid = 1'b0;
            bus.cache_inval = 1'b0;
            return;
        end
        e.hit        = hit;
        e.err        = !hit && (lat == 0);
        e.pixel      = e.err ? 1'b0 : pixel_of(addr);
        e.accept_cyc = cyc + 1;
        e.fetch_snap = fetch_cycles;
        if (!hit) plan_q.push_back('{lat: lat, waddr: w, abort: 1'b0});
        sb.push_back(e);
        issued++;
        if (inv_acc) m_vld = 1'b0;
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.cache_inval = inv_mid;
        @(negedge clk);
        bus.cache_inval = 1'b0;
        guard = 0;
        while (rsp_count != issued && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (rsp_count != issued) begin
            fail_now("rsp_wait", "response not delivered in time");
            issued = rsp_count;
            sb.delete();
        end
        if (inv_mid) m_vld = 1'b0;
        else if (!hit && lat != 0) begin
            m_vld   = 1'b1;
            m_waddr = w;
        end
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [29:0] a;
        int          lat;
        int          r;
        int          guard;
        bus.req_valid    = 1'b1;
        bus.req_bit_addr = 30'h045;
        bus.cache_inval  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_pixel, bus.rsp_err, bus.flash_req}), 64'(0));
        check("reset_flash_addr", 64'(bus.flash_addr), 64'(0));
        bus.req_valid = 1'b0;
        reset = 1'b0;
        check("req_ready_at_release", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        check("req_ready_after_release", 64'(bus.req_ready), 64'(1));

        mem[2] = 32'h0400_0000;
        do_req(30'h045, 4, 1'b0, 1'b0);
        do_req(30'h046, 2, 1'b0, 1'b0);
        do_req(30'h046, 3, 1'b1, 1'b0);
        do_req(30'h1000, 0, 1'b0, 1'b0);
        do_req(30'h1000, 3, 1'b0, 1'b0);
        do_req(30'h1001, 1, 1'b0, 1'b1);
        do_req(30'h1002, TMO, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) change_word(25'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 5) == 0) a = 30'($urandom);
            else a = {25'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            r = $urandom_range(0, 39);
            if (r == 0) lat = 0;
            else if (r == 1) lat = TMO;
            else lat = $urandom_range(1, 6);
            do_req(a, lat, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        // Reset two cycles into a fetch, then a stray rvalid after release.
        @(negedge clk);
        plan_q.push_back('{lat: 0, waddr: 25'h1ABCD, abort: 1'b1});
        bus.req_valid    = 1'b1;
        bus.req_bit_addr = {25'h1ABCD, 5'd3};
        bus.cache_inval  = 1'b1;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.cache_inval = 1'b0;
        @(negedge clk);
        check("fetch_before_reset", 64'(bus.flash_req), 64'(1));
        reset = 1'b1;
        #1;
        check("flash_req_async_reset", 64'(bus.flash_req), 64'(0));
        check("rsp_valid_async_reset", 64'(bus.rsp_valid), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_vld = 1'b0;
        @(negedge clk);
        late_req++;
        repeat (20) @(negedge clk);
        check("no_rsp_after_reset", 64'(bus.rsp_valid), 64'(0));
        check("no_fetch_after_reset", 64'(bus.flash_req), 64'(0));
        check("idle_after_reset", 64'(bus.req_ready), 64'(1));
        check("plan_queue_drained", 64'(plan_q.size()), 64'(0));
        check("responses_delivered", 64'(rsp_count), 64'(issued));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
